// File: rtl/updown_key_conditioner_pkg.sv
// updown_key_conditioner_pkg: arbiter state encoding and default parameters
package updown_key_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        UP_HELD   = 2'd1,
        DOWN_HELD = 2'd2,
        LOCKOUT   = 2'd3
    } arb_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_DB_W            = 8;
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
    localparam int DEF_REPEAT_DELAY    = 64;
    localparam int DEF_REPEAT_RATE     = 16;
`endif
endpackage

// File: rtl/updown_key_conditioner_if.sv
// updown_key_conditioner_if: raw keys in, command pulses and debounced levels out
interface updown_key_conditioner_if;
    logic key_up_raw;
    logic key_down_raw;
    logic up;
    logic down;
    logic up_level;
    logic down_level;
    logic conflict;

    modport master (
        output key_up_raw, key_down_raw,
        input  up, down, up_level, down_level, conflict
    );

    modport slave (
        input  key_up_raw, key_down_raw,
        output up, down, up_level, down_level, conflict
    );
endinterface

// File: rtl/updown_key_conditioner_key_debounce.sv
// key_debounce: two-flop synchronizer, debounce counter, stable level and edge flags
module key_debounce
    import updown_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DB_W            = DEF_DB_W
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_edge,
    output logic release_edge
);
    logic            sync1, sync2;
    logic [DB_W-1:0] cnt;
    logic            flip;

    assign flip = (sync2 != level) && (cnt == DB_W'(DEBOUNCE_CYCLES - 1));

    // Synchronize, count consecutive differing samples, flip the level once the run is long enough
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            cnt          <= '0;
            level        <= 1'b0;
            press_edge   <= 1'b0;
            release_edge <= 1'b0;
        end else begin
            sync1        <= raw;
            sync2        <= sync1;
            cnt          <= (sync2 == level || flip) ? '0 : (&cnt ? cnt : cnt + 1'b1);
            level        <= flip ? ~level : level;
            press_edge   <= flip & ~level;
            release_edge <= flip & level;
        end
    end
endmodule

// File: rtl/updown_key_conditioner.sv
// updown_key_conditioner: debounced up/down keys arbitrated into exclusive command pulses
// Optional auto-repeat while a single key is held: define UPDOWN_KEY_AUTO_REPEAT_EN.
module updown_key_conditioner
    import updown_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DB_W            = DEF_DB_W
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
    , parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY
    , parameter int REPEAT_RATE   = DEF_REPEAT_RATE
`endif
) (
    input logic clk,
    input logic reset,
    updown_key_conditioner_if.slave bus
);
    logic       up_press, up_rel, down_press, down_rel;
    arb_state_e state, state_nxt;
    logic       up_q, down_q, conflict_q;
    logic       up_nxt, down_nxt, conflict_nxt;
    logic       rpt_fire;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_up (
        .clk(clk), .reset(reset), .raw(bus.key_up_raw), .level(bus.up_level),
        .press_edge(up_press), .release_edge(up_rel)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_down (
        .clk(clk), .reset(reset), .raw(bus.key_down_raw), .level(bus.down_level),
        .press_edge(down_press), .release_edge(down_rel)
    );

`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
    logic [15:0] rpt_cnt;
    logic        rpt_started;
    logic        held;

    assign held     = (state == UP_HELD) || (state == DOWN_HELD);
    assign rpt_fire = held && (rpt_started ? rpt_cnt == 16'(REPEAT_RATE - 1)
                                           : rpt_cnt == 16'(REPEAT_DELAY - 1));

    // Repeat timer: first period is the delay, later periods the rate; any state change restarts it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_cnt     <= '0;
            rpt_started <= 1'b0;
        end else if (state_nxt != state || !held) begin
            rpt_cnt     <= '0;
            rpt_started <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt     <= '0;
            rpt_started <= 1'b1;
        end else begin
            rpt_cnt     <= rpt_cnt + 16'd1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Arbiter next state and next pulses; pulses only issue from IDLE or a held state that persists
    always_comb begin
        state_nxt    = state;
        up_nxt       = 1'b0;
        down_nxt     = 1'b0;
        conflict_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (up_press && down_press) begin
                    state_nxt    = LOCKOUT;
                    conflict_nxt = 1'b1;
                end else if (up_press) begin
                    state_nxt = UP_HELD;
                    up_nxt    = 1'b1;
                end else if (down_press) begin
                    state_nxt = DOWN_HELD;
                    down_nxt  = 1'b1;
                end
            end
            UP_HELD: begin
                if (down_press) state_nxt = LOCKOUT;
                else if (up_rel) state_nxt = IDLE;
                else up_nxt = rpt_fire;
            end
            DOWN_HELD: begin
                if (up_press) state_nxt = LOCKOUT;
                else if (down_rel) state_nxt = IDLE;
                else down_nxt = rpt_fire;
            end
            default: begin
                if (!bus.up_level && !bus.down_level) state_nxt = IDLE;
            end
        endcase
    end

    // State and registered command outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            up_q       <= up_nxt;
            down_q     <= down_nxt;
            conflict_q <= conflict_nxt;
        end
    end

    assign bus.up       = up_q;
    assign bus.down     = down_q;
    assign bus.conflict = conflict_q;
endmodule

// File: doc/updown_key_conditioner.md
Name: updown_key_conditioner

Overview:
- Upstream stage for the n-bit up/down counter.
- Turns two raw, asynchronous, bouncing push-button inputs into clean single-cycle up/down command pulses, which drive the counter's up/down inputs directly.
- Synchronizes and debounces each key, then detects press edges.
- Arbitrates so that up and down are never asserted together.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required before a key's debounced level changes. Legal range ≥2.
- DB_W, 8: debounce counter width. Must satisfy 2^DB_W > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 64: with AUTO_REPEAT_EN only. Cycles after the first pulse before auto-repeat starts.
- REPEAT_RATE, 16: with AUTO_REPEAT_EN only. Cycles between repeat pulses. Legal range ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- key_up_raw  input  1  raw up button, asynchronous, may bounce.
- key_down_raw  input  1  raw down button, asynchronous, may bounce.
- up  output  1  one-cycle up command pulse to the counter.
- down  output  1  one-cycle down command pulse to the counter.
- up_level  output  1  debounced up key level.
- down_level  output  1  debounced down key level.
- conflict  output  1  one-cycle pulse when both keys are pressed on the same cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; synchronizers, counters and stable levels cleared to 0.
  - FSM goes to IDLE.
  - Removal of reset is sampled on clk. Reset asserted mid-press drops every output to 0 immediately. A key still held after reset release must re-debounce before it is seen as pressed.
- Synchronizer: two flops per key; no logic between them.
- Debounce, per key:
  - While the synchronized level equals the stable level, the counter is held at 0.
  - While it differs, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 on a differing sample, the stable level flips and the counter clears.
  - Any sample equal to the stable level clears the counter, so a bounce restarts the count.
  - The counter saturates and never wraps.
- Press edge: the stable level goes 0→1. Release edge: 1→0.
- Latency: a clean raw press first sampled at edge E0 produces an up/down pulse that is high for exactly the clock cycle after edge E0+DEBOUNCE_CYCLES+2. Releases produce no pulse.
- Registered outputs: up, down, conflict.
- Arbiter FSM states: IDLE, UP_HELD, DOWN_HELD, LOCKOUT.
  - IDLE, up press only → UP_HELD, up=1 for one cycle.
  - IDLE, down press only → DOWN_HELD, down=1 for one cycle.
  - IDLE, both presses on the same cycle → LOCKOUT, conflict=1, no up/down pulse.
  - UP_HELD, down press → LOCKOUT, no pulse.
  - UP_HELD, up release → IDLE.
  - DOWN_HELD mirrors UP_HELD.
  - LOCKOUT → IDLE only when both stable levels are 0. No pulses while in LOCKOUT.
- Invariant: up & down == 0 in every cycle.

Optional Feature:
- Macro: UPDOWN_KEY_AUTO_REPEAT_EN.
- Defined:
  - In UP_HELD/DOWN_HELD, a repeat counter starts after the initial pulse.
  - After REPEAT_DELAY cycles it emits a further one-cycle pulse of the same direction, then one every REPEAT_RATE cycles while the state holds.
  - The counter clears on any state change.
  - The first repeat pulse falls exactly REPEAT_DELAY cycles after the initial pulse.
- Undefined: exactly one pulse per press; repeat counter and parameters unused.

Decomposition:
- Package updown_key_pkg:
  - arbiter state enum (IDLE, UP_HELD, DOWN_HELD, LOCKOUT, 2-bit encoding);
  - default parameter constants.
- Sub-module key_debounce (synchronizer + debounce counter + stable level + press/release edge flags), instantiated once per key.
- Arbiter FSM and the optional repeat logic live in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4; scenario 6 also sets REPEAT_DELAY=8, REPEAT_RATE=3.
1. Clean press: key_up_raw 0→1 held 20 cycles → one up pulse, 6 edges after the first sampling edge; up_level=1; down stays 0.
2. Bounce: key_down_raw toggles 1,0,1,0 each cycle then holds 1 → no pulse during bounce; one down pulse 6 edges after the final stable 1.
3. Simultaneous press: both raw inputs rise on the same cycle → conflict=1 for one cycle, no up/down pulse; still no pulse until both are released and one is pressed again.
4. Cross press: up held, then down pressed → single up pulse only; after both are released, a down press gives one down pulse.
5. Reset mid-press: reset=0 while up is held → all outputs 0 asynchronously; after reset=1 with up still held, one up pulse 6 edges later.
6. With UPDOWN_KEY_AUTO_REPEAT_EN: hold up for 20 cycles after the first pulse → further pulses 8, 11, 14, 17 and 20 cycles after the first pulse, none after release.
